// File: rtl/multicycle_core.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_core
// Function : Parametrised multi-cycle CPU core with handshaked instruction and
//            data memory ports, internal ALU, register file and sequencing FSM.
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_core #(
    parameter int  DATA_W   = 8,
    parameter int  NUM_REGS = 4,
    parameter int  PC_W     = 8,
    localparam int RA_W     = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [15:0]       imem_rdata,
    input  logic              imem_valid,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    input  logic              run,
    output logic [PC_W-1:0]   pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic              retire,
    output logic              illegal,
    output logic              ovf,
    input  logic [RA_W-1:0]   dbg_raddr,
    output logic [DATA_W-1:0] dbg_rdata
);

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_READ   = 3'd2,
        S_EXEC   = 3'd3,
        S_MEM    = 3'd4,
        S_WB     = 3'd5,
        S_PCUPD  = 3'd6,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [3:0] c_OP_HALT = 4'h0;
    localparam logic [3:0] c_OP_ADD  = 4'h1;
    localparam logic [3:0] c_OP_SUB  = 4'h2;
    localparam logic [3:0] c_OP_AND  = 4'h3;
    localparam logic [3:0] c_OP_OR   = 4'h4;
    localparam logic [3:0] c_OP_XOR  = 4'h5;
    localparam logic [3:0] c_OP_SLT  = 4'h6;
    localparam logic [3:0] c_OP_LI   = 4'h7;
    localparam logic [3:0] c_OP_IL0  = 4'h8;
    localparam logic [3:0] c_OP_IL1  = 4'h9;
    localparam logic [3:0] c_OP_LW   = 4'hA;
    localparam logic [3:0] c_OP_SW   = 4'hB;
    localparam logic [3:0] c_OP_BEQ  = 4'hC;
    localparam logic [3:0] c_OP_BNE  = 4'hD;
    localparam logic [3:0] c_OP_J    = 4'hE;

    state_t              state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d, npc_q, npc_d;
    logic [15:0]         ir_q, ir_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d;
    logic [DATA_W-1:0]   rf_q [NUM_REGS];
    logic [DATA_W-1:0]   rf_d [NUM_REGS];
    logic                imem_req_q, imem_req_d;
    logic                dmem_req_q, dmem_req_d;
    logic                dmem_we_q, dmem_we_d;
    logic [DATA_W-1:0]   dmem_addr_q, dmem_addr_d;
    logic [DATA_W-1:0]   dmem_wdata_q, dmem_wdata_d;
    logic                halted_q, halted_d;
    logic                retire_q, retire_d;
    logic                illegal_q, illegal_d;
    logic                ovf_q, ovf_d;
    logic                armed_q, armed_d;

    logic [3:0]          w_op;
    logic [RA_W-1:0]     w_rd, w_rs0, w_rs1;
    logic [DATA_W-1:0]   w_sum, w_diff, w_li;
    logic                w_add_ovf, w_sub_ovf, w_slt, w_eq, w_writes_rd;
    logic [PC_W-1:0]     w_pc_inc, w_br_off, w_br_tgt, w_jmp_tgt;

    assign w_op  = ir_q[15:12];
    assign w_rd  = ir_q[8 +: RA_W];
    assign w_rs0 = ir_q[4 +: RA_W];
    assign w_rs1 = ir_q[0 +: RA_W];

    assign w_sum     = a_q + b_q;
    assign w_diff    = a_q - b_q;
    assign w_add_ovf = (a_q[DATA_W-1] == b_q[DATA_W-1]) && (w_sum[DATA_W-1] != a_q[DATA_W-1]);
    assign w_sub_ovf = (a_q[DATA_W-1] != b_q[DATA_W-1]) && (w_diff[DATA_W-1] != a_q[DATA_W-1]);
    assign w_slt     = $signed(a_q) < $signed(b_q);
    assign w_eq      = (a_q == b_q);
    assign w_li      = DATA_W'(ir_q[7:0]);

    // Branch offset is the rd field sign-extended to the PC width
    assign w_pc_inc  = pc_q + PC_W'(1);
    assign w_br_off  = PC_W'($signed(ir_q[11:8]));
    assign w_br_tgt  = w_pc_inc + w_br_off;
    assign w_jmp_tgt = PC_W'(ir_q[11:0]);

    assign w_writes_rd = ((w_op >= c_OP_ADD) && (w_op <= c_OP_LI)) || (w_op == c_OP_LW);

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        npc_d        = npc_q;
        ir_d         = ir_q;
        a_d          = a_q;
        b_d          = b_q;
        res_d        = res_q;
        rf_d         = rf_q;
        imem_req_d   = imem_req_q;
        dmem_req_d   = dmem_req_q;
        dmem_we_d    = dmem_we_q;
        dmem_addr_d  = dmem_addr_q;
        dmem_wdata_d = dmem_wdata_q;
        halted_d     = halted_q;
        retire_d     = 1'b0;
        illegal_d    = 1'b0;
        ovf_d        = ovf_q;
        armed_d      = armed_q;

        case (state_q)
            S_FETCH: begin
                imem_req_d = 1'b1;
                if (imem_req_q && imem_valid) begin
                    ir_d       = imem_rdata;
                    imem_req_d = 1'b0;
                    state_d    = S_DECODE;
                end
            end
            S_DECODE: begin
                if (w_op == c_OP_HALT) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                    armed_d  = 1'b0;
                end else begin
                    state_d   = S_READ;
                    illegal_d = (w_op == c_OP_IL0) || (w_op == c_OP_IL1);
                end
            end
            S_READ: begin
                a_d     = rf_q[w_rs0];
                b_d     = rf_q[w_rs1];
                state_d = S_EXEC;
            end
            S_EXEC: begin
                npc_d   = w_pc_inc;
                state_d = S_WB;
                case (w_op)
                    c_OP_ADD: begin
                        res_d = w_sum;
                        if (w_add_ovf) ovf_d = 1'b1;
                    end
                    c_OP_SUB: begin
                        res_d = w_diff;
                        if (w_sub_ovf) ovf_d = 1'b1;
                    end
                    c_OP_AND: res_d = a_q & b_q;
                    c_OP_OR:  res_d = a_q | b_q;
                    c_OP_XOR: res_d = a_q ^ b_q;
                    c_OP_SLT: res_d = DATA_W'(w_slt);
                    c_OP_LI:  res_d = w_li;
                    c_OP_BEQ: if (w_eq)  npc_d = w_br_tgt;
                    c_OP_BNE: if (!w_eq) npc_d = w_br_tgt;
                    c_OP_J:   npc_d = w_jmp_tgt;
                    c_OP_LW, c_OP_SW: begin
                        dmem_req_d   = 1'b1;
                        dmem_we_d    = (w_op == c_OP_SW);
                        dmem_addr_d  = a_q;
                        dmem_wdata_d = b_q;
                        state_d      = S_MEM;
                    end
                    default: ;
                endcase
            end
            S_MEM: begin
                if (dmem_req_q && dmem_ack) begin
                    dmem_req_d = 1'b0;
                    dmem_we_d  = 1'b0;
                    if (!dmem_we_q) res_d = dmem_rdata;
                    state_d    = S_WB;
                end
            end
            S_WB: begin
                if (w_writes_rd) rf_d[w_rd] = res_q;
                retire_d = 1'b1;
                state_d  = S_PCUPD;
            end
            S_PCUPD: begin
                pc_d       = npc_q;
                imem_req_d = 1'b1;
                state_d    = S_FETCH;
            end
            S_HALT: begin
                // The first HALT cycle is not armed, so a run pulse must arrive afresh
                armed_d = 1'b1;
                if (run && armed_q) begin
                    pc_d       = w_pc_inc;
                    imem_req_d = 1'b1;
                    halted_d   = 1'b0;
                    state_d    = S_FETCH;
                end
            end
            default: state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= S_FETCH;
            pc_q         <= '0;
            npc_q        <= '0;
            ir_q         <= '0;
            a_q          <= '0;
            b_q          <= '0;
            res_q        <= '0;
            for (int i = 0; i < NUM_REGS; i++) rf_q[i] <= '0;
            imem_req_q   <= 1'b0;
            dmem_req_q   <= 1'b0;
            dmem_we_q    <= 1'b0;
            dmem_addr_q  <= '0;
            dmem_wdata_q <= '0;
            halted_q     <= 1'b0;
            retire_q     <= 1'b0;
            illegal_q    <= 1'b0;
            ovf_q        <= 1'b0;
            armed_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            npc_q        <= npc_d;
            ir_q         <= ir_d;
            a_q          <= a_d;
            b_q          <= b_d;
            res_q        <= res_d;
            rf_q         <= rf_d;
            imem_req_q   <= imem_req_d;
            dmem_req_q   <= dmem_req_d;
            dmem_we_q    <= dmem_we_d;
            dmem_addr_q  <= dmem_addr_d;
            dmem_wdata_q <= dmem_wdata_d;
            halted_q     <= halted_d;
            retire_q     <= retire_d;
            illegal_q    <= illegal_d;
            ovf_q        <= ovf_d;
            armed_q      <= armed_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign imem_addr  = pc_q;
    assign dmem_req   = dmem_req_q;
    assign dmem_we    = dmem_we_q;
    assign dmem_addr  = dmem_addr_q;
    assign dmem_wdata = dmem_wdata_q;
    assign pc         = pc_q;
    assign state      = state_q;
    assign halted     = halted_q;
    assign retire     = retire_q;
    assign illegal    = illegal_q;
    assign ovf        = ovf_q;
    assign dbg_rdata  = rf_q[dbg_raddr];

endmodule
`default_nettype wire
